// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control unit for an RV32 subset (lw, sw, R-type, I-type ALU,
// beq, jal). One state per instruction step and one step per clock. It
// drives every datapath select and write enable. It also decodes the
// opcode held in the instruction register into the immediate-extender
// select.
//
// Ports
//   i_clk          rising-edge clock
//   i_reset_n      synchronous active-low reset
//   i_op           instr[6:0] from the instruction register
//   i_funct3       instr[14:12]
//   i_funct7b5     instr[30]
//   i_zero         ALU zero flag for the current cycle
//   o_immsrc       extender select: 00 I, 01 S, 10 B, 11 J
//   o_alusrca      ALU A select: 00 PC, 01 OldPC, 10 register A
//   o_alusrcb      ALU B select: 00 WriteData, 01 ImmExt, 10 constant 4
//   o_resultsrc    result select: 00 ALUOut, 01 Data, 10 ALUResult
//   o_adrsrc       memory address select: 0 PC, 1 Result
//   o_alucontrol   ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
//   o_irwrite      instruction register load
//   o_pcwrite      PC load
//   o_regwrite     register file write
//   o_memwrite     data memory write
module mc_controller (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic [1:0] o_immsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_resultsrc,
  output logic       o_adrsrc,
  output logic [2:0] o_alucontrol,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_regwrite,
  output logic       o_memwrite
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic       w_adrsrc;
  logic [1:0] w_aluop;
  logic       w_irwrite;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_regwrite;
  logic       w_memwrite;
  logic [2:0] w_alucontrol;
  logic [1:0] w_immsrc;

  // ALU decoder. Subtract on funct3=000 only for R-type (op[5]=1) with
  // funct7b5 set, so addi with imm[10]=1 still adds.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic       op5,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5);
    logic [2:0] res;
    res = ALU_ADD;
    case (aluop)
      2'b00: res = ALU_ADD;
      2'b01: res = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  res = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  res = ALU_SLT;
          3'b110:  res = ALU_OR;
          3'b111:  res = ALU_AND;
          default: res = ALU_ADD;
        endcase
      end
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // State register with synchronous reset to FETCH.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; unknown encodings and unsupported opcodes go back to FETCH.
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECUTER;
          OP_I:         w_next_state = S_EXECUTEI;
          OP_JAL:       w_next_state = S_JAL;
          OP_BEQ:       w_next_state = S_BEQ;
          default:      w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (i_op == OP_LW) begin
          w_next_state = S_MEMREAD;
        end else begin
          w_next_state = S_MEMWRITE;
        end
      end
      S_MEMREAD:  w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = S_FETCH;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_ALUWB;
      S_BEQ:      w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Moore output decode of the current state.
  always_comb begin
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_adrsrc    = 1'b0;
    w_aluop     = 2'b00;
    w_irwrite   = 1'b0;
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_pcupdate  = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
      end
      S_DECODE: begin
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b10;
      end
      S_EXECUTEI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluop   = 2'b10;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
      end
      S_JAL: begin
        w_alusrca  = 2'b01;
        w_alusrcb  = 2'b10;
        w_pcupdate = 1'b1;
      end
      S_BEQ: begin
        w_alusrca = 2'b10;
        w_branch  = 1'b1;
        w_aluop   = 2'b01;
      end
      default: begin
        w_alusrca = 2'b00;
      end
    endcase
  end

  // ALU control from aluop and the instruction function fields.
  always_comb begin
    w_alucontrol = alu_decode(w_aluop, i_op[5], i_funct3, i_funct7b5);
  end

  // Immediate format select, purely from the opcode.
  always_comb begin
    w_immsrc = 2'b00;
    case (i_op)
      OP_LW, OP_I: w_immsrc = 2'b00;
      OP_SW:       w_immsrc = 2'b01;
      OP_BEQ:      w_immsrc = 2'b10;
      OP_JAL:      w_immsrc = 2'b11;
      default:     w_immsrc = 2'b00;
    endcase
  end

  // Output stage: everything except immsrc is held at 0 while reset is low,
  // so no write fires during a reset cycle even if the state is mid-instruction.
  always_comb begin
    o_immsrc = w_immsrc;
    if (!i_reset_n) begin
      o_alusrca    = 2'b00;
      o_alusrcb    = 2'b00;
      o_resultsrc  = 2'b00;
      o_adrsrc     = 1'b0;
      o_alucontrol = 3'b000;
      o_irwrite    = 1'b0;
      o_pcwrite    = 1'b0;
      o_regwrite   = 1'b0;
      o_memwrite   = 1'b0;
    end else begin
      o_alusrca    = w_alusrca;
      o_alusrcb    = w_alusrcb;
      o_resultsrc  = w_resultsrc;
      o_adrsrc     = w_adrsrc;
      o_alucontrol = w_alucontrol;
      o_irwrite    = w_irwrite;
      // Branch takes effect in the same cycle the ALU reports zero.
      o_pcwrite    = w_pcupdate | (w_branch & i_zero);
      o_regwrite   = w_regwrite;
      o_memwrite   = w_memwrite;
    end
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V core. It holds the main state machine and steers every datapath mux and write enable, one instruction step per clock. It also decodes the opcode held in the instruction register into `immsrc`, which drives the immediate extender directly downstream. It supports lw, sw, R-type ALU, I-type ALU, beq and jal.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag for the current cycle.
- `immsrc`  out  2  extender select: 00 I, 01 S, 10 B, 11 J.
- `alusrca`  out  2  ALU A select: 00 PC, 01 OldPC, 10 register A.
- `alusrcb`  out  2  ALU B select: 00 WriteData, 01 ImmExt, 10 constant 4.
- `resultsrc`  out  2  Result select: 00 ALUOut, 01 Data, 10 ALUResult.
- `adrsrc`  out  1  memory address select: 0 PC, 1 Result.
- `alucontrol`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `irwrite`  out  1  instruction register load.
- `pcwrite`  out  1  PC load.
- `regwrite`  out  1  register file write.
- `memwrite`  out  1  data memory write.

## Operation

**Opcodes**
- lw 0000011, sw 0100011, R 0110011, I 0010011, beq 1100011, jal 1101111.

**immsrc** (purely combinational from `op`)
- lw or I → 00; sw → 01; beq → 10; jal → 11; any other opcode → 00.

**States** (Moore outputs; any output not listed is 0)
- FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10, aluop=00.
- DECODE: alusrca=01, alusrcb=01, aluop=00.
- MEMADR: alusrca=10, alusrcb=01, aluop=00.
- MEMREAD: adrsrc=1, resultsrc=00.
- MEMWB: resultsrc=01, regwrite=1.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1.
- EXECUTER: alusrca=10, alusrcb=00, aluop=10.
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10.
- ALUWB: resultsrc=00, regwrite=1.
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcupdate=1, aluop=00.
- BEQ: alusrca=10, alusrcb=00, resultsrc=00, branch=1, aluop=01.

**Next state**
- FETCH → DECODE.
- DECODE → MEMADR (lw or sw), EXECUTER (R), EXECUTEI (I), JAL (jal), BEQ (beq), or FETCH for any other opcode, which executes as a no-op.
- MEMADR → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD → MEMWB → FETCH.
- MEMWRITE → FETCH.
- EXECUTER and EXECUTEI → ALUWB → FETCH.
- JAL → ALUWB.
- BEQ → FETCH.

**Write enables and ALU decode**
- pcwrite = pcupdate | (branch & zero).
- ALU decoder:
  - aluop 00 → add; aluop 01 → sub.
  - aluop 10 decodes funct3:
    - 000 → sub if op[5] and funct7b5 are both 1, otherwise add. An I-type addi is therefore never sub.
    - 010 → slt; 110 → or; 111 → and; any other funct3 → add.

## Timing
- Reset:
  - Sampled on a rising edge while reset_n=0, the state register becomes FETCH.
  - While reset_n=0, irwrite, pcwrite, regwrite and memwrite are forced to 0, and all selects are forced to 0 except immsrc.
  - The first cycle after reset_n rises is a live FETCH.
- A reset asserted mid-instruction abandons that instruction. No write enable asserts in any reset cycle.
- State advances once per clock and there are no stall inputs.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, unsupported opcode 2.
- All outputs except pcwrite depend only on the state, plus `op`/funct fields where listed. pcwrite in BEQ follows `zero` combinationally within the same cycle.
- `op` is only meaningful from DECODE onward. In FETCH, immsrc reflects the previous instruction and is a don't-care.

## Test plan
- **Reset:** hold reset_n=0 for 3 edges in the middle of a lw (in MEMREAD) → all four enables read 0 throughout. After release the first cycle is FETCH with irwrite=1 and pcwrite=1.
- **lw then sw:**
  - op=0000011 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. regwrite=1 only in cycle 5 with resultsrc=01. immsrc=00.
  - op=0100011 → memwrite=1 only in cycle 4 with adrsrc=1. immsrc=01.
- **R-type:** op=0110011, funct3=000, funct7b5=1 → alucontrol=001 in EXECUTER. With funct3=111 → 010; with funct3=010 → 101.
- **I-type:** op=0010011, funct3=000, funct7b5=1 → alucontrol=000 (add, not sub). ALUWB follows with regwrite=1.
- **beq:** op=1100011 with zero=1 → pcwrite=1 in BEQ, immsrc=10, alucontrol=001. With zero=0 → pcwrite=0. Either way the next state is FETCH.
- **jal and unsupported opcode:**
  - op=1101111 → JAL with pcwrite=1, then ALUWB with regwrite=1. immsrc=11.
  - op=1111111 → DECODE then FETCH, with no regwrite or memwrite.
